// File: rtl/ayatsuki_lsu_if.sv
// Data-bus side of the load/store unit: request/acknowledge bus with wait states.
// The master (LSU) holds bus_req_o and its qualifiers until bus_ack_i, which carries read data.
interface ayatsuki_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int LANES = DATA_W / 8;

  logic              bus_req_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [LANES-1:0]  bus_be_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic              bus_ack_i;
  logic [DATA_W-1:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/ayatsuki_lsu.sv
// Load/store unit: one pipeline request per bus transaction, lane byte enables,
// store replication, load extraction/extension, alignment/size/timeout errors.
module ayatsuki_lsu #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  // Handshake: a request transfers on a rising edge where req_valid_i & req_ready_o & ~flush_i.
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [4:0]        req_rd_i,
  input  logic              flush_i,
  ayatsuki_lsu_if.master    bus,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              stall_o,
  output logic              err_o,
  output logic [1:0]        err_cause_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic              dbg_state_o
);
  localparam int LANES = DATA_W / 8;
  localparam int LB    = $clog2(LANES);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [LANES-1:0]  bus_be_q, bus_be_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [4:0]        rd_q, rd_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              err_q, err_d;
  logic [1:0]        err_cause_q, err_cause_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic              accept, illegal, misal, timeout_hit, drop_now;
  logic [LANES-1:0]  be_base, be_req;
  logic [DATA_W-1:0] wdata_rep, rd_shift, ld_mask, ld_ext;
  logic              ld_sign;

  // Request decode: byte-enable pattern, replicated store data, alignment and size checks.
  always_comb begin
    illegal   = (req_size_i == 2'd3) && (DATA_W < 64);
    misal     = 1'b0;
    be_base   = '0;
    wdata_rep = '0;
    case (req_size_i)
      2'd0: begin
        be_base[0] = 1'b1;
        wdata_rep  = {LANES{req_wdata_i[7:0]}};
      end
      2'd1: begin
        misal        = req_addr_i[0];
        be_base[1:0] = '1;
        wdata_rep    = {(LANES/2){req_wdata_i[15:0]}};
      end
      2'd2: begin
        misal        = |req_addr_i[1:0];
        be_base[3:0] = '1;
        wdata_rep    = {(LANES/4){req_wdata_i[31:0]}};
      end
      default: begin
        misal     = |req_addr_i[2:0];
        be_base   = '1;
        wdata_rep = req_wdata_i;
      end
    endcase
    be_req = be_base << req_addr_i[LB-1:0];
  end

  // Load extraction from the lane the byte address selects.
  always_comb begin
    rd_shift = bus.bus_rdata_i >> {addr_q[LB-1:0], 3'b000};
    ld_mask  = '0;
    case (size_q)
      2'd0:    begin ld_mask[7:0]  = '1; ld_sign = rd_shift[7];  end
      2'd1:    begin ld_mask[15:0] = '1; ld_sign = rd_shift[15]; end
      2'd2:    begin ld_mask[31:0] = '1; ld_sign = rd_shift[31]; end
      default: begin ld_mask = '1; ld_sign = rd_shift[DATA_W-1]; end
    endcase
    ld_ext = (rd_shift & ld_mask) | ((ld_sign & ~uns_q) ? ~ld_mask : '0);
  end

  assign accept      = req_valid_i & req_ready_o & ~flush_i;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign drop_now    = drop_q | flush_i;

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    cnt_d       = cnt_q;
    drop_d      = drop_q;
    addr_d      = addr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rd_d        = rd_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    err_d       = 1'b0;
    err_cause_d = err_cause_q;
    err_addr_d  = err_addr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = req_addr_i;
          size_d   = req_size_i;
          uns_d    = req_unsigned_i;
          rd_d     = req_rd_i;
          bus_we_d = req_we_i;
          if (illegal || misal) begin
            // Faulting requests never reach the bus; the error is reported next cycle.
            err_d       = 1'b1;
            err_cause_d = illegal ? 2'd3 : 2'd1;
            err_addr_d  = req_addr_i;
          end else begin
            state_d     = BUSY;
            bus_req_d   = 1'b1;
            bus_addr_d  = {req_addr_i[ADDR_W-1:LB], {LB{1'b0}}};
            bus_be_d    = be_req;
            bus_wdata_d = wdata_rep;
            cnt_d       = '0;
            drop_d      = 1'b0;
          end
        end
      end
      BUSY: begin
        if (bus.bus_ack_i) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          drop_d    = 1'b0;
          if (!bus_we_q && !drop_now) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = ld_ext;
          end
        end else if (timeout_hit) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          drop_d    = 1'b0;
          if (!drop_now) begin
            err_d       = 1'b1;
            err_cause_d = 2'd2;
            err_addr_d  = addr_q;
          end
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          drop_d = drop_now;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      rd_q        <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
      err_cause_q <= '0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rd_q        <= rd_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
      err_cause_q <= err_cause_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign req_ready_o     = (state_q == IDLE);
  assign stall_o         = (state_q == BUSY) | (req_valid_i & ~req_ready_o);
  assign bus.bus_req_o   = bus_req_q;
  assign bus.bus_we_o    = bus_we_q;
  assign bus.bus_addr_o  = bus_addr_q;
  assign bus.bus_be_o    = bus_be_q;
  assign bus.bus_wdata_o = bus_wdata_q;
  assign wb_valid_o      = wb_valid_q;
  assign wb_rd_o         = wb_rd_q;
  assign wb_data_o       = wb_data_q;
  assign err_o           = err_q;
  assign err_cause_o     = err_cause_q;
  assign err_addr_o      = err_addr_q;
  assign dbg_state_o     = state_q;
endmodule
